imem_arbiter: RTL and testbench

Shares the single-port 64K-word instruction ROM/RAM between the fetch unit (PC reads) and the program loader (instruction writes at boot or debug). Requests use a req/gnt handshake; one transaction is outstanding at a time. Fetch has priority, and a starvation counter guarantees the loader forward progress. Sits between the IFU, the loader and the instruction memory macro.

---
 rtl/imem_arb_pkg.sv | 29 ++
 rtl/imem_arb_pick.sv | 51 +++++
 rtl/imem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_imem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg
// Shared types and constants for the instruction-memory arbiter.
//   arb_state_e    : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   OWN_FETCH/LOAD : encoding of the owner of the in-flight transaction
//   DEF_MEM_LAT    : default memory read latency in cycles
//   DEF_STARVE_MAX : default number of consecutive fetch grants allowed
//                    while the loader is waiting
//   cnt_width()    : bit width needed to hold a counter value 0..max_val
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_LOAD  = 1'b1;

  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

  // Always at least one bit so a counter with range 0..0 stays legal.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// imem_arb_pick
// Winner selection between fetch and loader, plus the loader starvation
// counter. Fetch normally wins; once STARVE_MAX fetch grants have gone by
// while the loader kept requesting, the loader is forced through.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   en            : arbiter is in IDLE and out of reset (grants allowed)
//   f_req, l_req  : fetch / loader requests
//   pick_f        : fetch wins this cycle (used directly as f_gnt)
//   pick_l        : loader wins this cycle (used directly as l_gnt)
module imem_arb_pick
  import imem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic f_req,
  input  logic l_req,
  output logic pick_f,
  output logic pick_l
);

  localparam int CW = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  // The loader wins when fetch is absent or when it has been starved long
  // enough; fetch takes every other contested cycle.
  always_comb begin
    starved = (starve_cnt == CNT_MAX);
    pick_l  = en & l_req & (~f_req | starved);
    pick_f  = en & f_req & ~pick_l;
  end

  // Counts fetch grants that bypass a waiting loader. Any cycle without a
  // loader request, or a loader grant, restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!l_req || pick_l) begin
      starve_cnt <= '0;
    end else if (pick_f && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter
// Shares the single-port instruction memory between the fetch unit (reads)
// and the program loader (writes). One transaction is in flight at a time:
// grant in IDLE, strobe the memory in ISSUE, wait MEM_LAT cycles, then
// report completion in RESP.
// Optional feature macro: IMEM_ARB_MISALIGN_EN adds f_err, which flags a
// fetch whose byte address is not word aligned (f_rdata forced to 0).
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   f_req/f_addr/f_gnt        : fetch request handshake (byte address)
//   f_rvalid/f_rdata          : fetch response pulse and registered data
//   l_req/l_addr/l_wdata/l_gnt: loader write request handshake
//   l_done                    : loader write completion pulse
//   m_en/m_we/m_addr/m_wdata  : memory strobe, write enable, word address, data
//   m_rdata                   : memory read data, valid MEM_LAT cycles after m_en
//   busy                      : a transaction is in flight
//   f_err (macro only)        : misaligned fetch flag, pulses with f_rvalid
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic [31:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_done,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
`ifdef IMEM_ARB_MISALIGN_EN
  ,
  output logic              f_err
`endif
);

  localparam int LW = cnt_width(MEM_LAT - 1);

  arb_state_e    state, state_nxt;
  logic          owner;
  logic [LW-1:0] wait_cnt;
  logic          grant_en;
  logic          pick_f, pick_l;
  logic          last_wait;
  logic          unused_addr_bits;

`ifdef IMEM_ARB_MISALIGN_EN
  logic misalign;
`endif

  // Only word-index bits reach the memory; the rest of each byte address
  // is deliberately dropped.
  assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                              l_addr[31:ADDR_W+2], l_addr[1:0]};

  // Gating with rst keeps the grants low while reset is held, even though
  // the requests may already be up.
  assign grant_en  = (state == IDLE) & rst;
  assign last_wait = (state == WAIT) && (wait_cnt == '0);

  imem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .en     (grant_en),
    .f_req  (f_req),
    .l_req  (l_req),
    .pick_f (pick_f),
    .pick_l (pick_l)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the combinational grant/busy outputs. Grants are only
  // visible in IDLE because pick_f/pick_l are already gated by grant_en.
  always_comb begin
    state_nxt = state;
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        f_gnt = pick_f;
        l_gnt = pick_l;
        if (pick_f || pick_l) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction datapath. The grant cycle latches owner, address and data
  // straight into the memory-side registers so m_* are valid in ISSUE.
  // The wait counter is loaded in ISSUE and reaches zero on the last WAIT
  // cycle, which is when read data is captured for the RESP pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= OWN_FETCH;
      wait_cnt <= '0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      f_rvalid <= 1'b0;
      f_rdata  <= '0;
      l_done   <= 1'b0;
`ifdef IMEM_ARB_MISALIGN_EN
      misalign <= 1'b0;
      f_err    <= 1'b0;
`endif
    end else begin
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      f_rvalid <= 1'b0;
      l_done   <= 1'b0;
`ifdef IMEM_ARB_MISALIGN_EN
      f_err    <= 1'b0;
`endif

      if (pick_f || pick_l) begin
        m_en    <= 1'b1;
        m_we    <= pick_l;
        owner   <= pick_l ? OWN_LOAD : OWN_FETCH;
        m_addr  <= pick_l ? l_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];
        m_wdata <= pick_l ? l_wdata : '0;
`ifdef IMEM_ARB_MISALIGN_EN
        misalign <= pick_f && (f_addr[1:0] != 2'b00);
`endif
      end

      if (state == ISSUE) begin
        wait_cnt <= LW'(MEM_LAT - 1);
      end else if ((state == WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 1'b1;
      end

      if (last_wait) begin
        if (owner == OWN_FETCH) begin
          f_rvalid <= 1'b1;
`ifdef IMEM_ARB_MISALIGN_EN
          f_rdata  <= misalign ? '0 : m_rdata;
          f_err    <= misalign;
`else
          f_rdata  <= m_rdata;
`endif
        end else begin
          l_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter
// Bench for imem_arbiter. The main instance (MEM_LAT=1) is attached to a
// behavioural RAM and tracked every cycle by a timeline model of the
// arbiter; a second instance (MEM_LAT=3) is exercised with a single fetch.
// Honours IMEM_ARB_MISALIGN_EN when the macro is defined.
module tb_imem_arbiter;

  localparam int LAT1   = 1;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;

  logic        f_req, f_gnt, f_rvalid;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_gnt, l_done;
  logic [31:0] l_addr, l_wdata;
  logic        m_en, m_we, busy;
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
`ifdef IMEM_ARB_MISALIGN_EN
  logic        f_err;
  logic        unused3_f_err;
`endif

  logic        f_req3, f_gnt3, f_rvalid3, busy3, m_en3, m_we3;
  logic [31:0] f_addr3, f_rdata3, m_rdata3;
  logic        unused3_l_gnt, unused3_l_done;
  logic [15:0] unused3_m_addr;
  logic [31:0] unused3_m_wdata;
  logic [2:0]  rdPipe3 = 3'b000;

  int    nVec = 0;
  int    nFail = 0;
  int    cyc = 0;
  string grantLog = "";
  bit    logGrants = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(LAT1), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt), .l_done(l_done),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
`ifdef IMEM_ARB_MISALIGN_EN
    , .f_err(f_err)
`endif
  );

  imem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(STARVE)) dut3 (
    .clk(clk), .rst(rst),
    .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_rvalid(f_rvalid3), .f_rdata(f_rdata3),
    .l_req(1'b0), .l_addr(32'h0), .l_wdata(32'h0), .l_gnt(unused3_l_gnt), .l_done(unused3_l_done),
    .m_en(m_en3), .m_we(m_we3), .m_addr(unused3_m_addr), .m_wdata(unused3_m_wdata),
    .m_rdata(m_rdata3), .busy(busy3)
`ifdef IMEM_ARB_MISALIGN_EN
    , .f_err(unused3_f_err)
`endif
  );

  // Memory for the main instance: read data is only valid in the single
  // cycle MEM_LAT after the strobe, garbage otherwise.
  logic [31:0] ram    [0:65535];
  logic [31:0] refMem [0:65535];
  logic        rdValid = 1'b0;
  logic [31:0] rdData = 32'h0;

  always @(posedge clk) begin
    rdValid <= 1'b0;
    if (m_en) begin
      if (m_we) ram[m_addr] <= m_wdata;
      else begin
        rdValid <= 1'b1;
        rdData  <= ram[m_addr];
      end
    end
  end
  assign m_rdata = rdValid ? rdData : 32'hDEADBEEF;

  // Memory for the MEM_LAT=3 instance: a fixed word, valid 3 cycles after m_en.
  always @(posedge clk) rdPipe3 <= {rdPipe3[1:0], m_en3 & ~m_we3};
  assign m_rdata3 = rdPipe3[2] ? 32'hCAFE0003 : 32'h0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    nVec++;
    nFail++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Timeline model: phase 0 is idle, phase k counts cycles since the grant.
  // Phase 1 strobes memory, phase LAT1+2 carries the response.
  int          phase = 0;
  int          starve = 0;
  logic        owner = 1'b0;
  logic [31:0] tAddr = 32'h0;
  logic [31:0] tData = 32'h0;
  logic [31:0] expRdata = 32'h0;

  always @(negedge clk) begin
    logic pf, pl;
    if (!rst) begin
      checkOutput("rst_f_gnt", 32'(f_gnt), 32'h0);
      checkOutput("rst_l_gnt", 32'(l_gnt), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_m_en", 32'(m_en), 32'h0);
      checkOutput("rst_m_we", 32'(m_we), 32'h0);
      checkOutput("rst_m_addr", 32'(m_addr), 32'h0);
      checkOutput("rst_m_wdata", m_wdata, 32'h0);
      checkOutput("rst_f_rvalid", 32'(f_rvalid), 32'h0);
      checkOutput("rst_f_rdata", f_rdata, 32'h0);
      checkOutput("rst_l_done", 32'(l_done), 32'h0);
`ifdef IMEM_ARB_MISALIGN_EN
      checkOutput("rst_f_err", 32'(f_err), 32'h0);
`endif
      phase = 0;
      starve = 0;
      expRdata = 32'h0;
    end else begin
      pf = 1'b0;
      pl = 1'b0;
      if (phase == 0) begin
        pl = l_req && (!f_req || starve == STARVE);
        pf = f_req && !pl;
      end
      if (phase == LAT1 + 2 && !owner) begin
        expRdata = refMem[tAddr[17:2]];
`ifdef IMEM_ARB_MISALIGN_EN
        if (tAddr[1:0] != 2'b00) expRdata = 32'h0;
`endif
      end
      checkOutput("f_gnt", 32'(f_gnt), 32'(pf));
      checkOutput("l_gnt", 32'(l_gnt), 32'(pl));
      checkOutput("busy", 32'(busy), 32'(phase != 0));
      checkOutput("m_en", 32'(m_en), 32'(phase == 1));
      checkOutput("m_we", 32'(m_we), 32'(phase == 1 && owner));
      checkOutput("f_rvalid", 32'(f_rvalid), 32'(phase == LAT1 + 2 && !owner));
      checkOutput("l_done", 32'(l_done), 32'(phase == LAT1 + 2 && owner));
      checkOutput("f_rdata", f_rdata, expRdata);
`ifdef IMEM_ARB_MISALIGN_EN
      checkOutput("f_err", 32'(f_err), 32'(phase == LAT1 + 2 && !owner && tAddr[1:0] != 2'b00));
`endif
      if (phase == 1) begin
        checkOutput("m_addr", 32'(m_addr), 32'(tAddr[17:2]));
        checkOutput("m_wdata", m_wdata, owner ? tData : 32'h0);
      end
      if (logGrants) begin
        if (f_gnt) grantLog = {grantLog, "F"};
        if (l_gnt) grantLog = {grantLog, "L"};
      end
      if (phase == LAT1 + 2 && owner) refMem[tAddr[17:2]] = tData;
      if (!l_req || pl) starve = 0;
      else if (pf && starve < STARVE) starve++;
      if (phase == 0) begin
        if (pf || pl) begin
          phase = 1;
          owner = pl;
          tAddr = pl ? l_addr : f_addr;
          tData = l_wdata;
        end
      end else if (phase == LAT1 + 2) begin
        phase = 0;
      end else begin
        phase++;
      end
    end
  end

  // One complete fetch or loader transaction; reports grant-to-response
  // latency in cycles and what the memory port showed in the ISSUE cycle.
  task automatic applyStimulus(input bit isLoad, input logic [31:0] addr, input logic [31:0] data,
                               output int lat, output logic [31:0] rdat,
                               output logic [31:0] issAddr, output logic [31:0] issWdata,
                               output logic issEn, output logic issWe, output logic err);
    bit got;
    lat = 0; rdat = 32'h0; issAddr = 32'h0; issWdata = 32'h0; issEn = 1'b0; issWe = 1'b0; err = 1'b0;
    @(posedge clk); #1;
    if (isLoad) begin l_req = 1'b1; l_addr = addr; l_wdata = data; end
    else begin f_req = 1'b1; f_addr = addr; end
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = isLoad ? l_gnt : f_gnt;
    end
    @(posedge clk); #1;
    if (isLoad) l_req = 1'b0; else f_req = 1'b0;
    if (!got) begin
      reportTimeout("grant_wait");
      return;
    end
    @(negedge clk);
    lat = 1;
    issEn = m_en; issWe = m_we; issAddr = 32'(m_addr); issWdata = m_wdata;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      lat++;
      got = isLoad ? l_done : f_rvalid;
    end
    if (!got) reportTimeout("response_wait");
    else begin
      rdat = f_rdata;
`ifdef IMEM_ARB_MISALIGN_EN
      err = f_err;
`endif
    end
  endtask

  // Waits for a grant on the main instance; returns the cycle it was seen.
  task automatic waitFetchGrant(output int gc);
    bit got = 1'b0;
    gc = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (f_gnt) begin got = 1'b1; gc = cyc; end
    end
    if (!got) reportTimeout("fetch_grant_wait");
  endtask

  initial begin
    int          lat, g1, g2, cnt, rvCyc;
    logic [31:0] rdat, issAddr, issWdata, d3;
    logic        issEn, issWe, err;
    bit          got;

    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 32'h5000_0000 | 32'(i);
      refMem[i] = 32'h5000_0000 | 32'(i);
    end
    ram[2] = 32'h2008000A;
    refMem[2] = 32'h2008000A;

    rst = 1'b0;
    f_req = 1'b1; f_addr = 32'h8;
    l_req = 1'b1; l_addr = 32'h10; l_wdata = 32'h0;
    f_req3 = 1'b0; f_addr3 = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_holds_f_gnt_low", 32'(f_gnt), 32'h0);
    @(posedge clk); #1;
    f_req = 1'b0; l_req = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single fetch of word 2.
    applyStimulus(1'b0, 32'h8, 32'h0, lat, rdat, issAddr, issWdata, issEn, issWe, err);
    checkOutput("fetch8_latency", 32'(lat), 32'd3);
    checkOutput("fetch8_rdata", rdat, 32'h2008000A);
    checkOutput("fetch8_m_en", 32'(issEn), 32'h1);
    checkOutput("fetch8_m_we", 32'(issWe), 32'h0);
    checkOutput("fetch8_m_addr", issAddr, 32'h2);

    // Loader write, then read it back.
    applyStimulus(1'b1, 32'h10, 32'h08000004, lat, rdat, issAddr, issWdata, issEn, issWe, err);
    checkOutput("load10_latency", 32'(lat), 32'd3);
    checkOutput("load10_m_we", 32'(issWe), 32'h1);
    checkOutput("load10_m_addr", issAddr, 32'h4);
    checkOutput("load10_m_wdata", issWdata, 32'h08000004);
    applyStimulus(1'b0, 32'h10, 32'h0, lat, rdat, issAddr, issWdata, issEn, issWe, err);
    checkOutput("readback10_rdata", rdat, 32'h08000004);

    // Upper byte-address bits beyond the word index are ignored.
    applyStimulus(1'b0, 32'hFFFC0008, 32'h0, lat, rdat, issAddr, issWdata, issEn, issWe, err);
    checkOutput("highbits_m_addr", issAddr, 32'h2);
    checkOutput("highbits_rdata", rdat, 32'h2008000A);

    // Misaligned and aligned fetch of word 1.
    applyStimulus(1'b0, 32'h6, 32'h0, lat, rdat, issAddr, issWdata, issEn, issWe, err);
`ifdef IMEM_ARB_MISALIGN_EN
    checkOutput("misalign6_err", 32'(err), 32'h1);
    checkOutput("misalign6_rdata", rdat, 32'h0);
`else
    checkOutput("misalign6_rdata", rdat, 32'h50000001);
`endif
    applyStimulus(1'b0, 32'h4, 32'h0, lat, rdat, issAddr, issWdata, issEn, issWe, err);
    checkOutput("aligned4_err", 32'(err), 32'h0);
    checkOutput("aligned4_rdata", rdat, 32'h50000001);

    // Loader request raised while busy waits for IDLE: earliest grant N+4.
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h14;
    waitFetchGrant(g1);
    @(posedge clk); #1;
    f_req = 1'b0; l_req = 1'b1; l_addr = 32'h300; l_wdata = 32'h12345678;
    got = 1'b0; g2 = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (l_gnt) begin got = 1'b1; g2 = cyc; end
    end
    @(posedge clk); #1;
    l_req = 1'b0;
    if (!got) reportTimeout("busy_l_gnt_wait");
    else checkOutput("next_grant_spacing", 32'(g2 - g1), 32'd4);
    repeat (5) @(posedge clk);

    // Loader request dropped before it could be granted.
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h18;
    waitFetchGrant(g1);
    @(posedge clk); #1;
    f_req = 1'b0; l_req = 1'b1; l_addr = 32'h400; l_wdata = 32'h77777777;
    @(posedge clk); #1;
    l_req = 1'b0;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (l_gnt) cnt++;
    end
    checkOutput("dropped_req_grants", 32'(cnt), 32'h0);

    // Both requesters held continuously: the loader wins every fifth grant.
    grantLog = "";
    @(posedge clk); #1;
    logGrants = 1'b1;
    f_req = 1'b1; f_addr = 32'h100;
    l_req = 1'b1; l_addr = 32'h100; l_wdata = 32'hA5A50000;
    for (int n = 0; n < 200 && grantLog.len() < 10; n++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    f_req = 1'b0; l_req = 1'b0;
    logGrants = 1'b0;
    nVec++;
    if (grantLog != "FFFFLFFFFL") begin
      nFail++;
      $display("[TB] FAIL grant_order: got %s, expected FFFFLFFFFL", grantLog);
    end
    repeat (6) @(posedge clk);

    // Reset dropped in WAIT discards the response.
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h18;
    waitFetchGrant(g1);
    @(posedge clk); #1;
    f_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_f_rdata", f_rdata, 32'h0);
    checkOutput("midreset_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (f_rvalid) cnt++;
    end
    checkOutput("postreset_no_rvalid", 32'(cnt), 32'h0);
    applyStimulus(1'b0, 32'h8, 32'h0, lat, rdat, issAddr, issWdata, issEn, issWe, err);
    checkOutput("rerequest_latency", 32'(lat), 32'd3);
    checkOutput("rerequest_rdata", rdat, 32'h2008000A);

    // MEM_LAT=3 instance: response 5 cycles after the grant, busy 5 cycles.
    @(posedge clk); #1;
    f_req3 = 1'b1; f_addr3 = 32'h20;
    got = 1'b0; g1 = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (f_gnt3) begin got = 1'b1; g1 = cyc; end
    end
    @(posedge clk); #1;
    f_req3 = 1'b0;
    if (!got) reportTimeout("lat3_grant_wait");
    else begin
      cnt = 0; rvCyc = -1; d3 = 32'h0;
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (busy3) cnt++;
        if (f_rvalid3 && rvCyc < 0) begin rvCyc = cyc; d3 = f_rdata3; end
      end
      checkOutput("lat3_rvalid_delay", 32'(rvCyc - g1), 32'd5);
      checkOutput("lat3_busy_cycles", 32'(cnt), 32'd5);
      checkOutput("lat3_rdata", d3, 32'hCAFE0003);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
